// File: rtl/servo_ramp_ctrl_pkg.sv
// Shared servo sequencer definitions: FSM state encoding, default pulsewidth limits
// and the clamp helper used on command accept.
package servo_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } servo_state_e;

  localparam int PW_MIN_DEF  = 50;
  localparam int PW_MAX_DEF  = 250;
  localparam int PW_INIT_DEF = 150;

  function automatic int clamp_pw(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_ramp_ctrl_tick.sv
// Frame-rate tick generator: one-cycle tick every TICK_DIV enabled cycles.
// Dropping en clears the phase, so a re-enable always waits a full period.
module tick_gen #(
  parameter int TICK_DIV = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo position sequencer: accepts clamped targets, slews pulsewidth by STEP per
// tick, then waits SETTLE_TICKS ticks before pulsing done.
module servo_ramp_ctrl
  import servo_ramp_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 2000000,
  parameter int STEP         = 1,
  parameter int PW_MIN       = PW_MIN_DEF,
  parameter int PW_MAX       = PW_MAX_DEF,
  parameter int PW_INIT      = PW_INIT_DEF,
  parameter int SETTLE_TICKS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  output logic [WIDTH-1:0] pulsewidth,
  output logic             pwm_en,
  output logic             busy,
  output logic             done
);

  localparam int               SW      = $clog2(SETTLE_TICKS + 1);
  localparam logic [SW-1:0]    SET_END = SW'(SETTLE_TICKS - 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);

  servo_state_e        state;
  logic [WIDTH-1:0]    target;
  logic [SW-1:0]       settle_cnt;
  logic                armed;
  logic                tick;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]      diff_mag;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .tick (tick)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // One extra bit so the signed difference of two unsigned widths cannot wrap.
  assign diff     = $signed({1'b0, target}) - $signed({1'b0, pulsewidth});
  assign diff_mag = diff[WIDTH] ? (WIDTH+1)'(-diff) : (WIDTH+1)'(diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      target     <= WIDTH'(PW_INIT);
      pulsewidth <= WIDTH'(PW_INIT);
      settle_cnt <= '0;
      armed      <= 1'b0;
      pwm_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done   <= 1'b0;
      pwm_en <= enable & armed;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            target <= WIDTH'(clamp_pw(int'(cmd_target), PW_MIN, PW_MAX));
            armed  <= 1'b1;
            state  <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (tick) begin
            if (diff_mag <= STEP_X) begin
              pulsewidth <= target;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else if (!diff[WIDTH]) begin
              pulsewidth <= pulsewidth + STEP_W;
            end else begin
              pulsewidth <= pulsewidth - STEP_W;
            end
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            if (settle_cnt == SET_END) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: a move is modelled as a queue of per-tick pulsewidths
// (ramp steps, then settle ticks); done follows the last entry.
module tb_servo_ramp_ctrl;

  localparam int WIDTH = 8, TICK_DIV = 4, STEP = 10, SETTLE_TICKS = 2;
  localparam int PW_MIN = 50, PW_MAX = 250, PW_INIT = 150;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [WIDTH-1:0] cmd_target = '0;
  logic             cmd_ready, pwm_en, busy, done;
  logic [WIDTH-1:0] pulsewidth;

  int checks = 0;
  int errors = 0;

  servo_ramp_ctrl #(
    .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STEP(STEP), .PW_MIN(PW_MIN),
    .PW_MAX(PW_MAX), .PW_INIT(PW_INIT), .SETTLE_TICKS(SETTLE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_target(cmd_target), .pulsewidth(pulsewidth),
    .pwm_en(pwm_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m_pw;
  logic             m_pwen, m_done, m_armed;
  int               m_cnt;
  logic [WIDTH-1:0] m_q[$];

  function automatic void plan_move(input int from, input int req);
    int tgt, p;
    tgt = (req < PW_MIN) ? PW_MIN : (req > PW_MAX) ? PW_MAX : req;
    p = from;
    while ((tgt > p ? tgt - p : p - tgt) > STEP) begin
      p = (tgt > p) ? p + STEP : p - STEP;
      m_q.push_back(WIDTH'(p));
    end
    m_q.push_back(WIDTH'(tgt));
    for (int i = 0; i < SETTLE_TICKS; i++) m_q.push_back(WIDTH'(tgt));
  endfunction

  function automatic logic [WIDTH+3:0] exp_vec();
    return {m_pw, m_pwen, (m_q.size() != 0), m_done, (m_q.size() == 0)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pw = WIDTH'(PW_INIT); m_pwen = 0; m_done = 0; m_armed = 0; m_cnt = 0;
      m_q.delete();
    end else begin
      logic tk;
      tk = enable && (m_cnt == TICK_DIV - 1);
      m_pwen = enable && m_armed;
      m_done = 0;
      if (m_q.size() == 0 && cmd_valid) begin
        plan_move(int'(m_pw), int'(cmd_target));
        m_armed = 1;
      end else if (tk && m_q.size() != 0) begin
        m_pw = m_q.pop_front();
        if (m_q.size() == 0) m_done = 1;
      end
      m_cnt = enable ? (m_cnt + 1) % TICK_DIV : 0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== {8'd150, 4'b0001}) begin
        errors++;
        $display("FAIL reset_idle: got pw=%0d en=%b busy=%b done=%b rdy=%b want pw=150 en=0 busy=0 done=0 rdy=1",
                 pulsewidth, pwm_en, busy, done, cmd_ready);
      end
    end
  endtask

  task automatic test_ramp_up();
    int ndone = 0;
    logic [WIDTH-1:0] last_pw;
    logic [WIDTH-1:0] seen[$];
    enable = 1'b1; cmd_valid = 1'b1; cmd_target = 8'd200;
    last_pw = pulsewidth;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL ramp_up_cycle: got %h want %h", {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
      end
      if (pulsewidth !== last_pw) begin seen.push_back(pulsewidth); last_pw = pulsewidth; end
      if (done) ndone++;
    end
    checks++;
    if (seen.size() != 5) begin
      errors++;
      $display("FAIL ramp_up_steps: got %0d pw changes want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] !== WIDTH'(160 + 10 * i)) begin
          errors++;
          $display("FAIL ramp_up_value: step %0d got %0d want %0d", i, seen[i], 160 + 10 * i);
        end
      end
    end
    checks++;
    if (ndone != 1 || pulsewidth !== 8'd200) begin
      errors++;
      $display("FAIL ramp_up_done: got done_pulses=%0d pw=%0d want 1 and 200", ndone, pulsewidth);
    end
  endtask

  task automatic test_clamp_low();
    int ndone = 0;
    int min_pw = 255;
    cmd_valid = 1'b1; cmd_target = 8'd20;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL clamp_low_cycle: got %h want %h", {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
      end
      if (int'(pulsewidth) < min_pw) min_pw = int'(pulsewidth);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 1 || pulsewidth !== 8'd50 || min_pw != 50) begin
      errors++;
      $display("FAIL clamp_low_final: got done_pulses=%0d pw=%0d min=%0d want 1, 50, 50", ndone, pulsewidth, min_pw);
    end
  endtask

  task automatic test_partial_step();
    for (int pass = 0; pass < 2; pass++) begin
      int ndone = 0;
      cmd_valid = 1'b1; cmd_target = 8'd55;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (30) begin
        @(negedge clk);
        checks++;
        if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
          errors++;
          $display("FAIL partial_step_cycle: pass %0d got %h want %h", pass,
                   {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
        end
        if (done) ndone++;
      end
      checks++;
      if (ndone != 1 || pulsewidth !== 8'd55) begin
        errors++;
        $display("FAIL partial_step_final: pass %0d got done_pulses=%0d pw=%0d want 1 and 55", pass, ndone, pulsewidth);
      end
    end
  endtask

  task automatic test_freeze();
    int ndone = 0;
    logic [WIDTH-1:0] frozen;
    cmd_valid = 1'b1; cmd_target = 8'd150;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    enable = 1'b0;
    frozen = pulsewidth;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (pulsewidth !== frozen || pwm_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold: got pw=%0d en=%b busy=%b want pw=%0d en=0 busy=1", pulsewidth, pwm_en, busy, frozen);
      end
    end
    enable = 1'b1;
    repeat (80) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL freeze_resume: got %h want %h", {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
      end
      if (done) ndone++;
    end
    checks++;
    if (ndone != 1 || pulsewidth !== 8'd150) begin
      errors++;
      $display("FAIL freeze_final: got done_pulses=%0d pw=%0d want 1 and 150", ndone, pulsewidth);
    end
  endtask

  task automatic test_back_to_back();
    logic seen_done = 1'b0;
    cmd_valid = 1'b1; cmd_target = 8'd200;
    @(negedge clk);
    cmd_target = 8'd100;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cycle: got %h want %h", {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
      end
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (!seen_done || cmd_ready !== 1'b1 || pulsewidth !== 8'd200) begin
      errors++;
      $display("FAIL b2b_done: got done=%b rdy=%b pw=%0d want 1 1 200", seen_done, cmd_ready, pulsewidth);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({pulsewidth, pwm_en, busy, cmd_ready} !== {8'd150, 3'b001}) begin
      errors++;
      $display("FAIL mid_ramp_reset: got pw=%0d en=%b busy=%b rdy=%b want 150 0 0 1", pulsewidth, pwm_en, busy, cmd_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if ({pulsewidth, pwm_en, busy, done, cmd_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h want %h", i, {pulsewidth, pwm_en, busy, done, cmd_ready}, exp_vec());
      end
      rst        = ($urandom_range(0, 499) == 0);
      enable     = ($urandom_range(0, 15) != 0);
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_target = WIDTH'($urandom_range(0, 255));
    end
    rst = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp_low();
    test_partial_step();
    test_freeze();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
